// File: rtl/target_packet_decoder.sv
// Receive-side decoder for {payload[5:0], channel[1:0]} packet bytes.
// Target IDs on channel 3 are range-checked and must repeat before they commit; a watchdog tracks link activity.
module target_packet_decoder #(
  parameter int unsigned TARGET_MIN     = 1,
  parameter int unsigned TARGET_MAX     = 20,
  parameter int unsigned CONFIRM_COUNT  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000000,
  parameter int unsigned TIMEOUT_W      = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [5:0] target_id,
  output logic       target_valid,
  output logic       target_changed,
  output logic       err_range,
  output logic [5:0] ch0_data,
  output logic [5:0] ch1_data,
  output logic [5:0] ch2_data,
  output logic [2:0] ch_update,
  output logic       link_alive
);

  localparam int unsigned PAYLOAD_W = 6;
  localparam int unsigned CNT_W     = 3;

  typedef enum logic {ST_IDLE, ST_CONFIRM} state_e;

  state_e                 state_q;
  logic [PAYLOAD_W-1:0]   cand_q;
  logic [CNT_W-1:0]       match_cnt_q, match_cnt_d;
  logic [TIMEOUT_W-1:0]   wdog_q, wdog_d;

  logic [PAYLOAD_W-1:0]   payload;
  logic [1:0]             chan;
  logic                   in_range;
  logic                   wdog_hit;
  logic                   commit;

  // Byte decode, confirmation count and watchdog next value.
  always_comb begin
    payload  = rx_data[7:2];
    chan     = rx_data[1:0];
    in_range = (payload >= PAYLOAD_W'(TARGET_MIN)) && (payload <= PAYLOAD_W'(TARGET_MAX));
    if (state_q == ST_CONFIRM && payload == cand_q) begin
      match_cnt_d = match_cnt_q + CNT_W'(1);
    end else begin
      match_cnt_d = CNT_W'(1);
    end
    commit   = rx_valid && (chan == 2'b11) && in_range && (match_cnt_d == CNT_W'(CONFIRM_COUNT));
    wdog_hit = !rx_valid && (wdog_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
    if (rx_valid) begin
      wdog_d = '0;
    end else if (wdog_q == TIMEOUT_W'(TIMEOUT_CYCLES)) begin
      wdog_d = wdog_q;
    end else begin
      wdog_d = wdog_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cand_q         <= '0;
      match_cnt_q    <= '0;
      wdog_q         <= '0;
      target_id      <= '0;
      target_valid   <= 1'b0;
      target_changed <= 1'b0;
      err_range      <= 1'b0;
      ch0_data       <= '0;
      ch1_data       <= '0;
      ch2_data       <= '0;
      ch_update      <= '0;
      link_alive     <= 1'b0;
    end else begin
      target_changed <= 1'b0;
      err_range      <= 1'b0;
      ch_update      <= '0;
      wdog_q         <= wdog_d;

      if (rx_valid) begin
        link_alive <= 1'b1;
      end else if (wdog_hit) begin
        link_alive   <= 1'b0;
        target_valid <= 1'b0;
        state_q      <= ST_IDLE;
        cand_q       <= '0;
        match_cnt_q  <= '0;
      end

      if (rx_valid) begin
        case (chan)
          2'b00: begin
            ch0_data  <= payload;
            ch_update <= 3'b001;
          end
          2'b01: begin
            ch1_data  <= payload;
            ch_update <= 3'b010;
          end
          2'b10: begin
            ch2_data  <= payload;
            ch_update <= 3'b100;
          end
          default: begin
            if (!in_range) begin
              err_range   <= 1'b1;
              state_q     <= ST_IDLE;
              cand_q      <= '0;
              match_cnt_q <= '0;
            end else begin
              cand_q      <= payload;
              match_cnt_q <= match_cnt_d;
              state_q     <= commit ? ST_IDLE : ST_CONFIRM;
              // Pulse only when the committed ID is new or the target was invalid.
              if (commit) begin
                target_id      <= payload;
                target_valid   <= 1'b1;
                target_changed <= !target_valid || (payload != target_id);
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_target_packet_decoder.sv
// Bench for target_packet_decoder: behavioural reference model feeding a per-cycle scoreboard, plus directed spot checks.
module tb_target_packet_decoder;

  localparam int unsigned T_CYC   = 16;
  localparam int unsigned T_W     = 5;
  localparam int unsigned CONFIRM = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [5:0] target_id;
  logic       target_valid;
  logic       target_changed;
  logic       err_range;
  logic [5:0] ch0_data, ch1_data, ch2_data;
  logic [2:0] ch_update;
  logic       link_alive;

  target_packet_decoder #(
    .TARGET_MIN(1), .TARGET_MAX(20), .CONFIRM_COUNT(CONFIRM),
    .TIMEOUT_CYCLES(T_CYC), .TIMEOUT_W(T_W)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .target_id(target_id), .target_valid(target_valid), .target_changed(target_changed),
    .err_range(err_range), .ch0_data(ch0_data), .ch1_data(ch1_data), .ch2_data(ch2_data),
    .ch_update(ch_update), .link_alive(link_alive)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] id;
    logic       tv;
    logic       tc;
    logic       er;
    logic [5:0] c0;
    logic [5:0] c1;
    logic [5:0] c2;
    logic [2:0] cu;
    logic       la;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  exp_t       m;
  logic [5:0] m_cand;
  int         m_cnt;
  bit         m_confirming;
  int         m_idle;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic r);
    logic [5:0] p;
    p = d[7:2];
    if (r) begin
      m = '0;
      m_cand = '0;
      m_cnt = 0;
      m_confirming = 0;
      m_idle = 0;
      return;
    end
    m.tc = 0;
    m.er = 0;
    m.cu = '0;
    if (v) begin
      m_idle = 0;
      m.la = 1;
      if (d[1:0] == 2'd0) begin m.c0 = p; m.cu = 3'b001; end
      else if (d[1:0] == 2'd1) begin m.c1 = p; m.cu = 3'b010; end
      else if (d[1:0] == 2'd2) begin m.c2 = p; m.cu = 3'b100; end
      else if (p < 6'd1 || p > 6'd20) begin
        m.er = 1;
        m_confirming = 0;
        m_cnt = 0;
      end else begin
        if (m_confirming && p == m_cand) m_cnt++;
        else begin m_cand = p; m_cnt = 1; end
        if (m_cnt >= CONFIRM) begin
          m.tc = !m.tv || (m.id != m_cand);
          m.id = m_cand;
          m.tv = 1;
          m_confirming = 0;
        end else begin
          m_confirming = 1;
        end
      end
    end else begin
      if (m_idle == T_CYC - 1) begin
        m.la = 0;
        m.tv = 0;
        m_confirming = 0;
      end
      if (m_idle < T_CYC) m_idle++;
    end
  endtask

  // Drive one cycle, queue the expected outputs, then compare after the edge.
  task automatic tick(input logic v, input logic [7:0] d, input logic r);
    exp_t e;
    rx_valid = v;
    rx_data  = d;
    rst      = r;
    model_step(v, d, r);
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val("target_id", 32'(target_id), 32'(e.id));
      check_val("target_valid", 32'(target_valid), 32'(e.tv));
      check_val("target_changed", 32'(target_changed), 32'(e.tc));
      check_val("err_range", 32'(err_range), 32'(e.er));
      check_val("ch0_data", 32'(ch0_data), 32'(e.c0));
      check_val("ch1_data", 32'(ch1_data), 32'(e.c1));
      check_val("ch2_data", 32'(ch2_data), 32'(e.c2));
      check_val("ch_update", 32'(ch_update), 32'(e.cu));
      check_val("link_alive", 32'(link_alive), 32'(e.la));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = '0;
    m = '0;

    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    check_val("rst_target_id", 32'(target_id), 32'd0);
    check_val("rst_link_alive", 32'(link_alive), 32'd0);

    // Two ID-3 bytes on separated clocks commit
    tick(1'b1, 8'h0F, 1'b0);
    check_val("t1_no_commit_yet", 32'(target_valid), 32'd0);
    idle(1);
    tick(1'b1, 8'h0F, 1'b0);
    check_val("t1_id", 32'(target_id), 32'd3);
    check_val("t1_valid", 32'(target_valid), 32'd1);
    check_val("t1_changed", 32'(target_changed), 32'd1);
    check_val("t1_alive", 32'(link_alive), 32'd1);
    idle(1);
    check_val("t1_changed_drop", 32'(target_changed), 32'd0);

    // Candidate replaced before confirmation
    tick(1'b1, 8'h17, 1'b0);
    tick(1'b1, 8'h1B, 1'b0);
    check_val("t2_no_commit", 32'(target_id), 32'd3);
    tick(1'b1, 8'h1B, 1'b0);
    check_val("t2_id", 32'(target_id), 32'd6);
    check_val("t2_changed", 32'(target_changed), 32'd1);

    // Range boundaries
    tick(1'b1, 8'h03, 1'b0);
    check_val("t3_err_lo", 32'(err_range), 32'd1);
    tick(1'b1, 8'h57, 1'b0);
    check_val("t3_err_hi", 32'(err_range), 32'd1);
    check_val("t3_id_kept", 32'(target_id), 32'd6);
    tick(1'b1, 8'h53, 1'b0);
    tick(1'b1, 8'h53, 1'b0);
    check_val("t3_id20", 32'(target_id), 32'd20);
    // Same ID re-committed while valid gives no pulse
    tick(1'b1, 8'h53, 1'b0);
    tick(1'b1, 8'h53, 1'b0);
    check_val("t3_recommit_nopulse", 32'(target_changed), 32'd0);

    // Status byte interleaved inside a confirmation
    tick(1'b1, 8'h0F, 1'b0);
    tick(1'b1, 8'h29, 1'b0);
    check_val("t4_ch1", 32'(ch1_data), 32'd10);
    check_val("t4_upd", 32'(ch_update), 32'b010);
    tick(1'b1, 8'h0F, 1'b0);
    check_val("t4_id", 32'(target_id), 32'd3);
    tick(1'b1, 8'hFE, 1'b0);
    check_val("t4_ch2", 32'(ch2_data), 32'd63);

    // Watchdog expiry on the 16th idle clock
    idle(15);
    check_val("t5_alive15", 32'(link_alive), 32'd1);
    idle(1);
    check_val("t5_dead", 32'(link_alive), 32'd0);
    check_val("t5_tv", 32'(target_valid), 32'd0);
    check_val("t5_id_kept", 32'(target_id), 32'd3);
    idle(3);
    tick(1'b1, 8'h0F, 1'b0);
    tick(1'b1, 8'h0F, 1'b0);
    check_val("t5_recommit_pulse", 32'(target_changed), 32'd1);
    idle(14);
    tick(1'b1, 8'h29, 1'b0);
    idle(2);
    check_val("t5_byte_saves", 32'(link_alive), 32'd1);
    check_val("t5_tv_kept", 32'(target_valid), 32'd1);

    // Reset mid-confirmation discards candidate
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'h0F, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'h0F, 1'b0);
    check_val("t6_no_commit", 32'(target_valid), 32'd0);
    idle(1);
    check_val("t6_tv", 32'(target_valid), 32'd0);

    // Randomised traffic with idle gaps against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 4) begin
        idle(int'($urandom_range(0, 18)));
      end else begin
        d[1:0] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) d[1:0] = 2'b11;
        d[7:2] = 6'($urandom_range(0, 1) == 1 ? $urandom_range(0, 22) : $urandom_range(0, 63));
        if ($urandom_range(0, 2) == 0) d[7:2] = 6'd5;
        tick(1'b1, d, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
